dll_burst_scheduler: RTL and testbench

Controller for the DLL-clocked ultrasonic transmit path. It first sequences the DLL: asserts the DLL reset for a fixed window, then waits for lock with a timeout. It then accepts burst requests and emits two 40 kHz pulse trains of N periods each: a reference channel `tx_ref` and a copy `tx_dly` shifted by a programmable number of `clk` cycles. It sits between the host/trigger logic and the DLL instance plus transducer output pins.

---
 rtl/dll_burst_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_dll_burst_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dll_burst_scheduler.sv
// Sequences the transmit DLL (reset window, lock wait with timeout) and then
// emits bursts of two 40 kHz square waves: a reference and a phase-delayed copy.
module dll_burst_scheduler #(
    parameter int HALF_PERIOD    = 337,
    parameter int DLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int PHASE_W        = 10,
    parameter int NP_W           = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dll_lock,
    input  logic               start,
    input  logic [NP_W-1:0]    num_pulses,
    input  logic [PHASE_W-1:0] phase_dly,
    output logic               dll_reset,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic               abort,
    output logic               lock_err,
    output logic               tx_ref,
    output logic               tx_dly
);

    localparam int HC_W   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int PH_MAX = 2 * HALF_PERIOD - 1;
    localparam int PC_W   = $clog2(2 * HALF_PERIOD);
    localparam int TM_MAX = (DLL_RST_CYCLES > LOCK_TIMEOUT) ? DLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int TM_W   = (TM_MAX > 1) ? $clog2(TM_MAX) : 1;

    typedef enum logic [2:0] {
        S_DLL_RST, S_WAIT_LOCK, S_IDLE, S_BURST, S_TAIL, S_ERR
    } state_t;

    state_t                      state_q, state_d;
    logic [1:0]                  sync_q;
    logic [TM_W-1:0]             tmr_q, tmr_d;
    logic [NP_W-1:0]             np_q, np_d;
    logic [PC_W-1:0]             dcnt_q, dcnt_d;
    logic                        arm_q, arm_d;
    logic [1:0][HC_W-1:0]        half_q, half_d;
    logic [1:0][NP_W-1:0]        per_q, per_d;
    logic [1:0]                  run_q, run_d;
    logic [1:0]                  tx_q, tx_d;
    logic                        done_q, done_d;
    logic                        abort_q, abort_d;
    logic [1:0]                  fin;
    logic [PC_W-1:0]             dcap;
    logic                        lock_s;

    function automatic logic [PC_W-1:0] clamp_phase(input logic [PHASE_W-1:0] p);
        if (32'(p) > 32'(PH_MAX)) return PC_W'(PH_MAX);
        return PC_W'(p);
    endfunction

    assign lock_s = sync_q[1];
    assign dcap   = clamp_phase(phase_dly);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_DLL_RST;
            sync_q  <= '0;
            tmr_q   <= '0;
            np_q    <= '0;
            dcnt_q  <= '0;
            arm_q   <= 1'b0;
            half_q  <= '0;
            per_q   <= '0;
            run_q   <= '0;
            tx_q    <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], dll_lock};
            tmr_q   <= tmr_d;
            np_q    <= np_d;
            dcnt_q  <= dcnt_d;
            arm_q   <= arm_d;
            half_q  <= half_d;
            per_q   <= per_d;
            run_q   <= run_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        np_d    = np_q;
        dcnt_d  = dcnt_q;
        arm_d   = arm_q;
        half_d  = half_q;
        per_d   = per_q;
        run_d   = run_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        fin     = '0;

        // Index 0 is the reference generator, index 1 the delayed one.
        for (int g = 0; g < 2; g++) begin
            if (run_q[g]) begin
                if (half_q[g] == HC_W'(HALF_PERIOD - 1)) begin
                    half_d[g] = '0;
                    if (tx_q[g]) begin
                        tx_d[g] = 1'b0;
                    end else if (per_q[g] == np_q - NP_W'(1)) begin
                        run_d[g] = 1'b0;
                        fin[g]   = 1'b1;
                    end else begin
                        per_d[g] = per_q[g] + NP_W'(1);
                        tx_d[g]  = 1'b1;
                    end
                end else begin
                    half_d[g] = half_q[g] + HC_W'(1);
                end
            end
        end

        // Down-counter hits zero at this edge: delayed output rises next cycle.
        if (arm_q) begin
            dcnt_d = dcnt_q - PC_W'(1);
            if (dcnt_q == PC_W'(1)) begin
                arm_d     = 1'b0;
                run_d[1]  = 1'b1;
                tx_d[1]   = 1'b1;
                half_d[1] = '0;
                per_d[1]  = '0;
            end
        end

        case (state_q)
            S_DLL_RST: begin
                tmr_d = tmr_q + TM_W'(1);
                if (tmr_q == TM_W'(DLL_RST_CYCLES - 1)) begin
                    state_d = S_WAIT_LOCK;
                    tmr_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                tmr_d = tmr_q + TM_W'(1);
                if (lock_s) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end else if (tmr_q == TM_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = S_ERR;
                    tmr_d   = '0;
                end
            end
            S_IDLE: begin
                if (!lock_s) begin
                    state_d = S_DLL_RST;
                end else if (start) begin
                    if (num_pulses == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = S_BURST;
                        np_d      = num_pulses;
                        run_d[0]  = 1'b1;
                        tx_d[0]   = 1'b1;
                        half_d[0] = '0;
                        per_d[0]  = '0;
                        if (dcap == '0) begin
                            run_d[1]  = 1'b1;
                            tx_d[1]   = 1'b1;
                            half_d[1] = '0;
                            per_d[1]  = '0;
                        end else begin
                            arm_d  = 1'b1;
                            dcnt_d = dcap;
                        end
                    end
                end
            end
            S_BURST, S_TAIL: begin
                if (!lock_s) begin
                    state_d = S_DLL_RST;
                    abort_d = 1'b1;
                    run_d   = '0;
                    tx_d    = '0;
                    arm_d   = 1'b0;
                    tmr_d   = '0;
                end else if (state_q == S_BURST && fin[0]) begin
                    if ((run_q[1] && !fin[1]) || arm_q) begin
                        state_d = S_TAIL;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else if (state_q == S_TAIL && fin[1]) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_ERR: begin
                if (start) state_d = S_DLL_RST;
            end
            default: state_d = S_DLL_RST;
        endcase
    end

    assign dll_reset = (state_q == S_DLL_RST);
    assign ready     = (state_q == S_IDLE);
    assign busy      = (state_q == S_BURST) || (state_q == S_TAIL);
    assign lock_err  = (state_q == S_ERR);
    assign done      = done_q;
    assign abort     = abort_q;
    assign tx_ref    = tx_q[0];
    assign tx_dly    = tx_q[1];

endmodule

// File: tb/tb_dll_burst_scheduler.sv
// Scoreboard bench for dll_burst_scheduler: expected output edges and level
// probes are queued by the stimulus and consumed by a negedge monitor.
module tb_dll_burst_scheduler;

    localparam int H  = 4;
    localparam int NW = 8;
    localparam int PW = 10;

    logic          clk;
    logic          rst_n;
    logic          dll_lock;
    logic          start;
    logic [NW-1:0] num_pulses;
    logic [PW-1:0] phase_dly;
    logic          dll_reset, ready, busy, done, abort, lock_err, tx_ref, tx_dly;

    dll_burst_scheduler #(
        .HALF_PERIOD(H), .DLL_RST_CYCLES(4), .LOCK_TIMEOUT(50), .PHASE_W(PW), .NP_W(NW)
    ) dut (
        .clk(clk), .reset(rst_n), .dll_lock(dll_lock), .start(start),
        .num_pulses(num_pulses), .phase_dly(phase_dly),
        .dll_reset(dll_reset), .ready(ready), .busy(busy), .done(done),
        .abort(abort), .lock_err(lock_err), .tx_ref(tx_ref), .tx_dly(tx_dly)
    );

    typedef struct { int cyc; int kind; } ev_t;
    typedef struct { int cyc; int sig; int val; } pr_t;

    ev_t eq[$];
    pr_t pq[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_errs = 0;
    bit  mon_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic string kname(input int k);
        case (k)
            0: return "ref_rise";  1: return "ref_fall";
            2: return "dly_rise";  3: return "dly_fall";
            4: return "busy_rise"; 5: return "busy_fall";
            6: return "done";      default: return "abort";
        endcase
    endfunction

    function automatic string sname(input int s);
        case (s)
            0: return "dll_reset"; 1: return "ready";  2: return "busy";
            3: return "done";      4: return "abort";  5: return "lock_err";
            6: return "tx_ref";    7: return "tx_dly"; default: return "sb_pending";
        endcase
    endfunction

    function automatic int sig_val(input int s);
        case (s)
            0: return int'(dll_reset); 1: return int'(ready);  2: return int'(busy);
            3: return int'(done);      4: return int'(abort);  5: return int'(lock_err);
            6: return int'(tx_ref);    7: return int'(tx_dly); default: return eq.size();
        endcase
    endfunction

    task automatic ev_seen(input int k);
        ev_t e;
        n_checks++;
        if (eq.size() == 0) begin
            n_errs++;
            $display("FAIL %s: unexpected event at cycle %0d, none expected", kname(k), cyc);
        end else begin
            e = eq.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                n_errs++;
                $display("FAIL %s: got %s at cycle %0d, expected %s at cycle %0d",
                         kname(k), kname(k), cyc, kname(e.kind), e.cyc);
            end
        end
    endtask

    // Monitor: edge events against the scoreboard, then level probes due this cycle.
    initial begin
        logic p_ref, p_dly, p_busy;
        pr_t  p;
        int   act;
        p_ref = 1'b0; p_dly = 1'b0; p_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && mon_en) begin
                if (tx_ref && !p_ref) ev_seen(0);
                if (!tx_ref && p_ref) ev_seen(1);
                if (tx_dly && !p_dly) ev_seen(2);
                if (!tx_dly && p_dly) ev_seen(3);
                if (busy && !p_busy)  ev_seen(4);
                if (!busy && p_busy)  ev_seen(5);
                if (done)             ev_seen(6);
                if (abort)            ev_seen(7);
            end
            p_ref = tx_ref; p_dly = tx_dly; p_busy = busy;
            while (pq.size() > 0 && pq[0].cyc == cyc) begin
                p = pq.pop_front();
                act = sig_val(p.sig);
                n_checks++;
                if (act != p.val) begin
                    n_errs++;
                    $display("FAIL %s: cycle %0d got %0d, expected %0d", sname(p.sig), cyc, act, p.val);
                end
            end
        end
    end

    task automatic probe(input int c, input int s, input int v);
        pr_t p;
        p.cyc = c; p.sig = s; p.val = v;
        pq.push_back(p);
    endtask

    task automatic push_ev(input int c, input int k);
        ev_t e;
        e.cyc = c; e.kind = k;
        eq.push_back(e);
    endtask

    function automatic bit wave(input int c, input int t0, input int n);
        if (c < t0 + 1 || c > t0 + 2 * H * n) return 1'b0;
        return (((c - t0 - 1) / H) % 2) == 0;
    endfunction

    // Reference model of one accepted burst at cycle t, events up to cycle cut.
    task automatic push_burst(input int t, input int n, input int pd, input int cut);
        int  d, last;
        bit  a, b;
        d    = (n == 0) ? 0 : ((pd > 2 * H - 1) ? 2 * H - 1 : pd);
        last = t + 2 * H * n + d + 1;
        for (int c = t + 1; c <= last && c <= cut; c++) begin
            a = wave(c - 1, t, n);     b = wave(c, t, n);
            if (b && !a) push_ev(c, 0);
            if (a && !b) push_ev(c, 1);
            a = wave(c - 1, t + d, n); b = wave(c, t + d, n);
            if (b && !a) push_ev(c, 2);
            if (a && !b) push_ev(c, 3);
            a = (n != 0) && (c - 1 >= t + 1) && (c - 1 <= last - 1);
            b = (n != 0) && (c <= last - 1);
            if (b && !a) push_ev(c, 4);
            if (a && !b) push_ev(c, 5);
            if (c == last) push_ev(c, 6);
        end
    endtask

    task automatic at_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic burst(input int t, input int n, input int pd);
        at_cyc(t);
        num_pulses = NW'(n); phase_dly = PW'(pd); start = 1'b1;
        push_burst(t, n, pd, 1 << 30);
        at_cyc(t + 1);
        start = 1'b0; num_pulses = 8'd7; phase_dly = 10'd1;
    endtask

    initial begin
        rst_n = 1'b1; dll_lock = 1'b0; start = 1'b0; num_pulses = '0; phase_dly = '0;
        #1 rst_n = 1'b0;
        probe(0, 0, 1); probe(0, 1, 0); probe(0, 2, 0); probe(0, 3, 0);
        probe(0, 4, 0); probe(0, 5, 0); probe(0, 6, 0); probe(0, 7, 0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;

        // Lock never arrives: timeout into ERR, then retry via start.
        for (int c = 0; c < 6; c++) probe(c, 0, (c < 4) ? 1 : 0);
        probe(53, 5, 0); probe(54, 5, 1);
        probe(60, 5, 1); probe(60, 0, 0);
        probe(61, 0, 1); probe(61, 5, 0);
        probe(62, 0, 1); probe(63, 0, 1); probe(64, 0, 1); probe(65, 0, 0);
        at_cyc(60); start = 1'b1; num_pulses = 8'd3;
        at_cyc(61); start = 1'b0;
        at_cyc(66);

        // Power-up with lock raised at cycle 10.
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        probe(3, 0, 1); probe(4, 0, 0); probe(12, 1, 0); probe(13, 1, 1);
        at_cyc(10); dll_lock = 1'b1;
        at_cyc(14); mon_en = 1'b1;

        burst(100, 3, 5);
        probe(132, 8, 0);
        burst(140, 0, 9);
        probe(143, 8, 0);
        burst(150, 2, 1023);
        probe(176, 8, 0);

        // Back-to-back: start held high through the done cycle of the first burst.
        at_cyc(180);
        num_pulses = 8'd1; phase_dly = 10'd2; start = 1'b1;
        push_burst(180, 1, 2, 1 << 30);
        push_burst(191, 2, 0, 1 << 30);
        at_cyc(183); num_pulses = 8'd2; phase_dly = 10'd0;
        at_cyc(192); start = 1'b0;
        probe(210, 8, 0);

        // Lock loss while only the delayed channel is still running.
        at_cyc(220);
        num_pulses = 8'd1; phase_dly = 10'd6; start = 1'b1;
        push_burst(220, 1, 6, 232);
        push_ev(233, 5); push_ev(233, 7);
        probe(232, 2, 1);
        probe(233, 0, 1); probe(233, 7, 0); probe(233, 3, 0);
        probe(236, 0, 1); probe(237, 0, 0);
        probe(242, 1, 0); probe(243, 1, 1); probe(244, 8, 0);
        at_cyc(221); start = 1'b0;
        at_cyc(230); dll_lock = 1'b0;
        at_cyc(240); dll_lock = 1'b1;
        at_cyc(246); mon_en = 1'b0;

        // Asynchronous reset in the middle of a high half-period.
        at_cyc(250);
        num_pulses = 8'd3; phase_dly = 10'd0; start = 1'b1;
        probe(252, 6, 1); probe(252, 2, 1);
        probe(253, 6, 0); probe(253, 7, 0); probe(253, 2, 0);
        probe(253, 0, 1); probe(253, 1, 0);
        at_cyc(251); start = 1'b0;
        at_cyc(252);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
